// File: rtl/mul_div_if.sv
// Datapath-side handshake and HI/LO read bus of the multi-cycle multiply/divide unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [5:0]       funct_i6;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, funct_i6, a_i, b_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, funct_i6, a_i, b_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one result bit per cycle,
// sign handled by magnitude arithmetic plus a final fixup cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [5:0]       F_MULT  = 6'h18;
  localparam logic [5:0]       F_MULTU = 6'h19;
  localparam logic [5:0]       F_DIV   = 6'h1A;
  localparam logic [5:0]       F_DIVU  = 6'h1B;
  localparam logic [5:0]       F_MTHI  = 6'h11;
  localparam logic [5:0]       F_MTLO  = 6'h13;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh, div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  // Even funct codes (MULT, DIV) are the signed variants.
  assign sgn   = ~bus.funct_i6[0];
  assign mag_a = (sgn && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign mag_b = (sgn && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  // Multiply: acc = {partial, multiplier}; add on the LSB, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_sh - {1'b0, opd_q};
  assign div_next  = div_trial[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quot = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          unique case (bus.funct_i6)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d = RUN;
              cnt_d   = '0;
              div_d   = bus.funct_i6[1];
              neg_d   = sgn & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
              rneg_d  = sgn & bus.a_i[WIDTH-1];
              dz_d    = (bus.b_i == '0);
              opd_d   = bus.funct_i6[1] ? mag_b : mag_a;
              acc_d   = {{WIDTH{1'b0}}, (bus.funct_i6[1] ? mag_a : mag_b)};
            end
            F_MTHI:  hi_d = bus.a_i;
            F_MTLO:  lo_d = bus.a_i;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = div_q ? div_next : mul_next;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // Divide by zero leaves the dividend magnitude as remainder, so the
          // remainder fixup restores the raw dividend; only LO needs forcing.
          lo_d = dz_q ? '1 : quot;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops push expected HI/LO, a monitor
// pops and compares on every done_o pulse.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(32)) bus();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && bus.done_o) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", 64'(bus.hi_o), 64'(e[63:32]));
        chk("result_lo", 64'(bus.lo_o), 64'(e[31:0]));
      end
    end
  end

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit inject);
    int n;
    exp_q.push_back({eh, el});
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i6 = f; bus.a_i = a; bus.b_i = b;
    @(negedge clk);
    bus.start_i = 1'b0; bus.funct_i6 = 6'($urandom); bus.a_i = $urandom; bus.b_i = $urandom;
    n = 0;
    while (bus.busy_o && n < 200) begin
      n++;
      if (inject && n == 5) begin
        bus.start_i = 1'b1; bus.funct_i6 = 6'h13; bus.a_i = 32'hDEADBEEF;
      end else if (inject && n == 6) begin
        bus.funct_i6 = 6'h18; bus.a_i = 32'd9; bus.b_i = 32'd9;
      end else if (inject && n == 7) begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'd33);
    chk({name, "_done_pulse"}, 64'(bus.done_o), 64'd1);
    @(negedge clk);
    chk({name, "_done_clear"}, 64'(bus.done_o), 64'd0);
  endtask

  task automatic move_to(input string name, input logic [5:0] f, input logic [31:0] a);
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i6 = f; bus.a_i = a;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk({name, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({name, "_done"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 1'b0; bus.funct_i6 = '0; bus.a_i = '0; bus.b_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy_o), 64'd0);
    chk("reset_done", 64'(bus.done_o), 64'd0);
    chk("reset_hi",   64'(bus.hi_o),   64'd0);
    chk("reset_lo",   64'(bus.lo_o),   64'd0);
    rst = 1'b0;

    run_op("mult_neg",   6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu_max",  6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_m1m1",  6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run_op("divu_7_2",   6'h1B, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0);
    run_op("div_m7_2",   6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_7_m2",   6'h1A, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);
    run_op("divu_5_0",   6'h1B, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b0);
    run_op("div_m7_0",   6'h1A, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run_op("div_min_m1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
    run_op("div_0_5",    6'h1A, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0);

    move_to("mthi", 6'h11, 32'h12345678);
    chk("mthi_hi", 64'(bus.hi_o), 64'h12345678);
    run_op("mult_inject", 6'h18, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);

    move_to("mthi2", 6'h11, 32'hA5A5A5A5);
    chk("mthi2_hi", 64'(bus.hi_o), 64'hA5A5A5A5);
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct_i6 = 6'h19; bus.a_i = 32'hFFFFFFFF; bus.b_i = 32'hFFFFFFFF;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", 64'(bus.busy_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy", 64'(bus.busy_o), 64'd0);
    chk("async_reset_hi",   64'(bus.hi_o),   64'd0);
    chk("async_reset_lo",   64'(bus.lo_o),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", 64'(bus.busy_o), 64'd0);
    chk("post_reset_lo",   64'(bus.lo_o),   64'd0);

    run_op("divu_100_7", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised multi-cycle multiply/divide unit. It sits beside the single-cycle ALU in the MIPS datapath and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU iteratively, one result bit per cycle, using a start/busy/done handshake.
- Supports MTHI/MTLO direct writes. HI/LO are read combinationally by the datapath for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width. Legal values: 4 and above.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk_i, input, 1, clock. All state updates on the rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- start_i, input, 1, operation request. Qualified by funct_i6; sampled only in IDLE.
- funct_i6, input, 6, MIPS funct code: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO.
- a_i, input, WIDTH, rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b_i, input, WIDTH, rt operand: multiplier or divisor.
- busy_o, output, 1, high while an iterative operation is in flight.
- done_o, output, 1, one-cycle pulse after an iterative result is written to HI/LO.
- hi_o, output, WIDTH, HI register.
- lo_o, output, WIDTH, LO register.

Behaviour:
- Reset (asynchronous, active-high):
  - State becomes IDLE.
  - busy_o=0, done_o=0, hi_o=0, lo_o=0; counter and datapath registers cleared.
  - Reset mid-operation abandons the operation: no done_o, HI/LO read 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i with funct 0x18–0x1B: latch operand magnitudes, the result-sign flags and the op; counter=0; go to RUN. busy_o rises on that same edge.
  - Signed ops take the magnitude via two's-complement negate of negative operands. Unsigned ops take operands as-is.
  - start_i with 0x11: hi_o<=a_i on that edge. With 0x13: lo_o<=a_i. No busy_o, no done_o.
  - start_i with any other funct is ignored.
- RUN: exactly WIDTH cycles, one iteration per edge; counter increments. When counter reaches WIDTH-1, go to FIX.
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator, LSB-first on the multiplier.
  - Divide: restoring division, MSB-first. Trial subtract in WIDTH+1 bits; quotient bit=1 when the result is non-negative.
- FIX: one cycle.
  - Apply the sign fixup and write HI/LO.
  - busy_o falls and done_o=1 for exactly one cycle; return to IDLE.
- Latency: start sampled at edge E0; HI/LO updated at edge E(WIDTH+1). busy_o is high for WIDTH+1 cycles, then done_o is high for the following cycle.
- start_i is ignored while busy_o=1, including MTHI/MTLO. HI/LO hold their values during RUN.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product. For MULT, negate the product iff the operand signs differ.
  - DIVU: lo=quotient, hi=remainder.
  - DIV: quotient is negative iff the signs differ (truncation toward zero); remainder takes the dividend's sign.
- Boundary results:
  - Divide by zero (DIV or DIVU): lo=all-ones, hi=a_i. Still takes the full latency.
  - DIV most-negative / -1: lo=most-negative, hi=0. No trap.
  - Operands of zero handled by the normal path, e.g. 0/x gives lo=0, hi=0.
- a_i, b_i and funct_i6 are don't-care after the start edge; the unit works from latched copies.
- All arithmetic is modular within the declared widths. No X may reach hi_o or lo_o.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD, b=7 -> busy_o high for 33 cycles; done_o pulses once at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands -> hi=0, lo=1.
- DIVU 7/2 -> lo=3, hi=1. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 in IDLE -> hi=0x12345678 next edge, no busy_o/done_o. Then MULT 2*3 started, and MTLO plus a second MULT pulsed mid-run -> both ignored; final hi=0, lo=6; exactly one done_o.
- Assert rst_i asynchronously at RUN cycle 10 -> busy_o, hi_o, lo_o go to 0 immediately; no done_o. After release, a new DIVU 100/7 -> lo=14, hi=2.
